mul_arbiter: RTL

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arb_pkg.sv | 17 +
 rtl/mul_arbiter_mul.sv | 19 +
 rtl/mul_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mul_arb_pkg.sv
// ---------------------------------------------------------------------------
// mul_arb_pkg
// Shared definitions for the two-requester multiplier arbiter.
//   state_e   : arbiter FSM states (IDLE, CALC, RESP)
//   N_DEFAULT : default operand width in bits (product is 2*N bits)
// ---------------------------------------------------------------------------
package mul_arb_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mul_arbiter_mul.sv
// ---------------------------------------------------------------------------
// mul
// Combinational unsigned N x N multiplier with a full 2N-bit product.
//   Y : output [2N-1:0]  product A*B, never truncated
//   A : input  [N-1:0]   unsigned operand
//   B : input  [N-1:0]   unsigned operand
// ---------------------------------------------------------------------------
module mul #(
    parameter int N = 4
) (
    output logic [2*N-1:0] Y,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B
);

    // Zero-extend both operands so the multiply is evaluated at 2N bits.
    assign Y = {{N{1'b0}}, A} * {{N{1'b0}}, B};

endmodule

// File: rtl/mul_arbiter.sv
// ---------------------------------------------------------------------------
// mul_arbiter
// Time-shares one unsigned N x N multiplier between two requesters.
// One operation is in flight at a time: IDLE accepts, CALC multiplies the
// registered operands, RESP presents the product until the owner takes it.
//
// Ports
//   clk, rst_n                 : clock, async active-low reset
//   reqK_valid/_a/_b (in)      : requester K operands pending
//   reqK_ready (out)           : requester K operands accepted this cycle
//   rspK_valid/_y (out)        : product for requester K available / value
//   rspK_ready (in)            : requester K consumes its product
//   busy (out)                 : FSM not in IDLE
// ---------------------------------------------------------------------------
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic           req1_ready,
    output logic           rsp0_valid,
    output logic [2*N-1:0] rsp0_y,
    input  logic           rsp0_ready,
    output logic           rsp1_valid,
    output logic [2*N-1:0] rsp1_y,
    input  logic           rsp1_ready,
    output logic           busy
);

    state_e         state_q, state_d;
    logic           last_q, last_d;     // index of the last granted requester
    logic           owner_q, owner_d;   // requester owning the in-flight op
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [2*N-1:0] y_q, y_d;
    logic [2*N-1:0] mul_y;
    logic           gnt;

    mul #(.N(N)) u_mul (
        .Y (mul_y),
        .A (a_q),
        .B (b_q)
    );

    // Single requester wins outright; on contention the one not granted
    // last wins. last_q resets to 1 so req0 takes the first contention.
    assign gnt = (req0_valid && req1_valid) ? ~last_q : req1_valid;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        a_d        = a_q;
        b_d        = b_q;
        y_d        = y_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = req0_valid && !gnt;
                req1_ready = req1_valid && gnt;
                if (req0_valid || req1_valid) begin
                    a_d     = gnt ? req1_a : req0_a;
                    b_d     = gnt ? req1_b : req0_b;
                    owner_d = gnt;
                    last_d  = gnt;
                    state_d = CALC;
                end
            end
            CALC: begin
                y_d     = mul_y;
                state_d = RESP;
            end
            RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
                // Only the owner's ready releases the response.
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign rsp0_y = y_q;
    assign rsp1_y = y_q;

endmodule
